// File: rtl/note_envelope.sv
// ADSR amplitude envelope: steps an 8-bit level once per beat and scales the
// incoming signed sample stream by it, with a one-cycle output latency.
module note_envelope #(
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 4,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_start,
  input  logic        note_release,
  input  logic        beat,
  input  logic [15:0] sample_in,
  input  logic        sample_in_ready,
  output logic [15:0] sample_out,
  output logic        sample_out_ready,
  output logic [7:0]  env_level,
  output logic        env_active
);

  localparam int unsigned LVL_W  = 8;
  localparam int unsigned SUM_W  = LVL_W + 1;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned PROD_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SMP_W-1:0]   sample_out_q, sample_out_d;
  logic               ready_q;
  logic               active_q;

  logic [SUM_W-1:0]   atk_sum;
  logic [SUM_W-1:0]   dec_floor;
  logic [LVL_W-1:0]   dec_next;
  logic [LVL_W-1:0]   rel_next;
  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] lvl_ext;
  logic signed [PROD_W-1:0] prod;

  // Saturating next-level candidates; 9-bit sums cannot wrap.
  assign atk_sum   = {1'b0, level_q} + SUM_W'(ATTACK_STEP);
  assign dec_floor = SUM_W'(SUSTAIN_LEVEL) + SUM_W'(DECAY_STEP);
  assign dec_next  = ({1'b0, level_q} >= dec_floor) ? level_q - LVL_W'(DECAY_STEP)
                                                    : LVL_W'(SUSTAIN_LEVEL);
  assign rel_next  = (level_q >= LVL_W'(RELEASE_STEP)) ? level_q - LVL_W'(RELEASE_STEP)
                                                       : '0;

  // Signed sample times non-negative level; |product| < 2^23 so 24 bits suffice.
  assign samp_ext = PROD_W'($signed(sample_in));
  assign lvl_ext  = PROD_W'($signed({1'b0, level_q}));
  assign prod     = samp_ext * lvl_ext;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    sample_out_d = sample_out_q;

    // Arithmetic shift floors toward -inf; uses the level before this edge's update.
    if (sample_in_ready) begin
      sample_out_d = SMP_W'(prod >>> 8);
    end

    if (note_start) begin
      state_d = ATTACK;
    end else if (note_release &&
                 (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (beat) begin
      case (state_q)
        ATTACK: begin
          if (atk_sum >= SUM_W'(255)) begin
            level_d = 8'hFF;
            state_d = DECAY;
          end else begin
            level_d = atk_sum[LVL_W-1:0];
          end
        end
        DECAY: begin
          level_d = dec_next;
          if (dec_next == LVL_W'(SUSTAIN_LEVEL)) begin
            state_d = SUSTAIN;
          end
        end
        SUSTAIN: begin
          level_d = LVL_W'(SUSTAIN_LEVEL);
        end
        RELEASE: begin
          level_d = rel_next;
          if (rel_next == '0) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          level_d = '0;
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= '0;
      sample_out_q <= '0;
      ready_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      sample_out_q <= sample_out_d;
      ready_q      <= sample_in_ready;
      active_q     <= (state_d != IDLE);
    end
  end

  assign sample_out       = sample_out_q;
  assign sample_out_ready = ready_q;
  assign env_level        = level_q;
  assign env_active       = active_q;

endmodule

// File: tb/tb_note_envelope.sv
// Bench for note_envelope: fixed vector table, scripted ADSR sequences and a
// randomized run, all checked against an arithmetic envelope model.
module tb_note_envelope;

  localparam int AS = 16;
  localparam int DS = 4;
  localparam int SL = 160;
  localparam int RS = 8;

  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_DEC  = 2;
  localparam int M_SUS  = 3;
  localparam int M_REL  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        note_start = 1'b0;
  logic        note_release = 1'b0;
  logic        beat = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_in_ready = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_ready;
  logic [7:0]  env_level;
  logic        env_active;

  always #5 clk = ~clk;

  note_envelope dut (
    .clk              (clk),
    .reset            (reset),
    .note_start       (note_start),
    .note_release     (note_release),
    .beat             (beat),
    .sample_in        (sample_in),
    .sample_in_ready  (sample_in_ready),
    .sample_out       (sample_out),
    .sample_out_ready (sample_out_ready),
    .env_level        (env_level),
    .env_active       (env_active)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode plus integer level, stepped with min/max arithmetic.
  int          m_mode  = M_IDLE;
  int          m_level = 0;
  logic [15:0] m_out   = '0;
  logic        m_rdy   = 1'b0;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic ns, input logic nr,
                            input logic bt, input logic [15:0] si, input logic sir);
    int p;
    if (r) begin
      m_mode = M_IDLE; m_level = 0; m_out = '0; m_rdy = 1'b0;
      return;
    end
    m_rdy = sir;
    if (sir) begin
      p = int'($signed(si)) * m_level;
      m_out = 16'(p >>> 8);
    end
    if (ns) begin
      m_mode = M_ATK;
    end else if (nr && (m_mode == M_ATK || m_mode == M_DEC || m_mode == M_SUS)) begin
      m_mode = M_REL;
    end else if (bt) begin
      case (m_mode)
        M_ATK: begin
          m_level = imin(m_level + AS, 255);
          if (m_level == 255) m_mode = M_DEC;
        end
        M_DEC: begin
          m_level = imax(m_level - DS, SL);
          if (m_level == SL) m_mode = M_SUS;
        end
        M_SUS: m_level = SL;
        M_REL: begin
          m_level = imax(m_level - RS, 0);
          if (m_level == 0) m_mode = M_IDLE;
        end
        default: m_level = 0;
      endcase
    end
  endtask

  // Drive one cycle's inputs, advance the model, and sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic ns, input logic nr,
                       input logic bt, input logic [15:0] si, input logic sir);
    reset = r; note_start = ns; note_release = nr; beat = bt;
    sample_in = si; sample_in_ready = sir;
    model_edge(r, ns, nr, bt, si, sir);
    @(posedge clk);
    #1;
    reset = 1'b0; note_start = 1'b0; note_release = 1'b0; beat = 1'b0;
    sample_in_ready = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"},  int'(env_level),        m_level);
    check({tag, ".active"}, int'(env_active),       int'(m_mode != M_IDLE));
    check({tag, ".ready"},  int'(sample_out_ready), int'(m_rdy));
    check({tag, ".out"},    int'(sample_out),       int'(m_out));
  endtask

  task automatic cyc(input logic r, input logic ns, input logic nr,
                     input logic bt, input logic [15:0] si, input logic sir);
    drive(r, ns, nr, bt, si, sir);
    check_model("model");
  endtask

  typedef struct {
    logic        r, ns, nr, bt, sir;
    logic [15:0] si;
    int          e_level;
    logic        e_act, e_rdy;
    logic [15:0] e_out;
  } vec_t;

  vec_t tbl [14];

  initial begin
    //            r    ns   nr   bt   sir  si        lvl act  rdy  out
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,  0, 1'b0,1'b0,16'h0000};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,  0, 1'b1,1'b0,16'h0000};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 16, 1'b1,1'b0,16'h0000};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h4000, 32, 1'b1,1'b1,16'h0400};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 32, 1'b1,1'b0,16'h0400};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 32, 1'b1,1'b0,16'h0400};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 24, 1'b1,1'b0,16'h0400};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h8000, 16, 1'b1,1'b1,16'hF400};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,16'h7FFF, 16, 1'b1,1'b1,16'h07FF};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,16'hFFFF, 16, 1'b1,1'b1,16'hFFFF};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,  8, 1'b1,1'b0,16'hFFFF};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,  0, 1'b0,1'b0,16'hFFFF};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h1234,  0, 1'b0,1'b1,16'h0000};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,  0, 1'b0,1'b0,16'h0000};

    #2;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].ns, tbl[i].nr, tbl[i].bt, tbl[i].si, tbl[i].sir);
      check($sformatf("vec%0d.level", i),  int'(env_level),        tbl[i].e_level);
      check($sformatf("vec%0d.active", i), int'(env_active),       int'(tbl[i].e_act));
      check($sformatf("vec%0d.ready", i),  int'(sample_out_ready), int'(tbl[i].e_rdy));
      check($sformatf("vec%0d.out", i),    int'(sample_out),       int'(tbl[i].e_out));
    end

    // Attack ramp from 0: 16 beats to 255.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      check("attack.ramp", int'(env_level), (k < 16) ? 16 * k : 255);
    end
    // Decay to sustain, then hold.
    for (int k = 1; k <= 34; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      check("decay.ramp", int'(env_level), (255 - 4 * k > 160) ? 255 - 4 * k : 160);
    end
    // Release down to idle.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("release.enter", int'(env_level), 160);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      check("release.ramp", int'(env_level), 160 - 8 * k);
      check("release.active", int'(env_active), int'(k < 20));
    end

    // Scaling at sustain level 160.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("scale.level", int'(env_level), 160);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b1);
    check("scale.pos.out", int'(sample_out), 16'h2800);
    check("scale.pos.rdy", int'(sample_out_ready), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("scale.hold.rdy", int'(sample_out_ready), 0);
    check("scale.hold.out", int'(sample_out), 16'h2800);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1);
    check("scale.neg.out", int'(sample_out), 16'hB000);

    // Simultaneous start and release at level 96 in release.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("restart.pre", int'(env_level), 96);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0);
    check("restart.hold", int'(env_level), 96);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("restart.step", int'(env_level), 112);

    // Reset in decay with a sample strobe pending.
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("decay.level", int'(env_level), 251);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b1);
    check("reset.level", int'(env_level), 0);
    check("reset.active", int'(env_active), 0);
    check("reset.ready", int'(sample_out_ready), 0);
    check("reset.out", int'(sample_out), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc(logic'($urandom_range(0, 299) == 0),
          logic'($urandom_range(0, 59) == 0),
          logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 2) == 0),
          16'($urandom),
          logic'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
